// File: rtl/shift_rotate_unit_if.sv
// Handshake and data bundle between an issuing datapath and shift_rotate_unit.
// The master drives the operand, amount and mode with start. The slave returns the result, carry, busy and done.
// WIDTH sets the operand width. SHW is derived from WIDTH and must not be overridden.
interface shift_rotate_unit_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) ();
    logic             start;    // request, sampled only while the unit is idle
    logic [WIDTH-1:0] in;       // operand
    logic [SHW-1:0]   amt;      // shift amount, 0..WIDTH-1
    logic [1:0]       mode;     // 00 LSL, 01 ROL, 10 LSR, 11 ASR
    logic [WIDTH-1:0] out;      // registered result
    logic             carry;    // last bit shifted or rotated out
    logic             busy;     // operation in flight (SHIFT or DONE)
    logic             done;     // one-cycle result-valid pulse

    modport master (
        output start, in, amt, mode,
        input  out, carry, busy, done
    );

    modport slave (
        input  start, in, amt, mode,
        output out, carry, busy, done
    );
endinterface

// File: rtl/shift_rotate_unit.sv
// Purpose: WIDTH-bit shifter/rotator (LSL, ROL, LSR, ASR) with registered result and carry-out.
// Latency: done is high amt+1 cycles after the start edge (1 cycle when amt==0). With SRU_BARREL_EN, done is always 1 cycle after the start edge.
// Backpressure: start is ignored, not queued, while busy. out and carry hold until the next accepted start.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   sru  shift_rotate_unit_if.slave carrying start/in/amt/mode in and out/carry/busy/done back
// Build option: define SRU_BARREL_EN to compute the result in one cycle with a barrel shifter.
// That build has no SHIFT state and no step counter.
module shift_rotate_unit #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    shift_rotate_unit_if.slave sru
);

    localparam logic [1:0] MODE_LSL = 2'b00;
    localparam logic [1:0] MODE_ROL = 2'b01;
    localparam logic [1:0] MODE_LSR = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
`ifndef SRU_BARREL_EN
        ST_SHIFT = 2'b01,
`endif
        ST_DONE  = 2'b10
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [WIDTH-1:0] r_data;
    logic             r_carry;
    logic             w_accept;

    // start is only honoured from IDLE. Any start seen during SHIFT or DONE is dropped.
    assign w_accept = (r_state == ST_IDLE) && sru.start;

`ifdef SRU_BARREL_EN
    // Single-cycle path. Each shift is done one bit wider so the bit that would
    // leave last in the iterative sequence lands in the extra position.
    //   left:  {0,in} << k puts in[WIDTH-k] at bit WIDTH (0 when k==0)
    //   right: {in,0} >> k puts in[k-1]     at bit 0     (0 when k==0)
    logic [WIDTH:0]        w_lsh;
    logic [WIDTH:0]        w_rsh;
    logic signed [WIDTH:0] w_asr;
    logic [SHW:0]          w_ramt;
    logic [WIDTH-1:0]      w_rol_wrap;
    logic [WIDTH-1:0]      w_res;
    logic                  w_res_carry;

    assign w_lsh  = {1'b0, sru.in} << sru.amt;
    assign w_rsh  = {sru.in, 1'b0} >> sru.amt;
    assign w_asr  = $signed({sru.in, 1'b0}) >>> sru.amt;
    // Bits wrapping round on a rotate. When amt==0 this shifts by WIDTH, giving 0.
    assign w_ramt     = (SHW+1)'(WIDTH) - {1'b0, sru.amt};
    assign w_rol_wrap = sru.in >> w_ramt;

    always_comb begin
        w_res       = sru.in;
        w_res_carry = 1'b0;
        case (sru.mode)
            MODE_LSL: begin
                w_res       = w_lsh[WIDTH-1:0];
                w_res_carry = w_lsh[WIDTH];
            end
            MODE_ROL: begin
                w_res       = w_lsh[WIDTH-1:0] | w_rol_wrap;
                w_res_carry = w_lsh[WIDTH];
            end
            MODE_LSR: begin
                w_res       = w_rsh[WIDTH:1];
                w_res_carry = w_rsh[0];
            end
            MODE_ASR: begin
                w_res       = w_asr[WIDTH:1];
                w_res_carry = w_asr[0];
            end
            default: begin
                w_res       = sru.in;
                w_res_carry = 1'b0;
            end
        endcase
    end

    // Next-state logic. An accepted start always finishes in one step.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (sru.start) w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_data  <= w_res;
            r_carry <= w_res_carry;
        end
    end

`else
    // Iterative path: one bit position per clock, counting amt down to 1.
    logic [SHW-1:0] r_cnt;
    logic [1:0]     r_mode;
    logic           w_amt_zero;

    assign w_amt_zero = (sru.amt == '0);

    // Next-state logic. A zero amount skips SHIFT entirely. The final shift
    // happens on the edge that leaves SHIFT with cnt==1.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (sru.start) begin
                    w_state_nxt = w_amt_zero ? ST_DONE : ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == SHW'(1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_mode  <= MODE_LSL;
        end else if (w_accept) begin
            r_data  <= sru.in;
            r_carry <= 1'b0;
            r_cnt   <= sru.amt;
            r_mode  <= sru.mode;
        end else if (r_state == ST_SHIFT) begin
            r_cnt <= r_cnt - SHW'(1);
            case (r_mode)
                MODE_LSL: begin
                    r_carry <= r_data[WIDTH-1];
                    r_data  <= {r_data[WIDTH-2:0], 1'b0};
                end
                MODE_ROL: begin
                    r_carry <= r_data[WIDTH-1];
                    r_data  <= {r_data[WIDTH-2:0], r_data[WIDTH-1]};
                end
                MODE_LSR: begin
                    r_carry <= r_data[0];
                    r_data  <= {1'b0, r_data[WIDTH-1:1]};
                end
                default: begin  // ASR: replicate the sign bit
                    r_carry <= r_data[0];
                    r_data  <= {r_data[WIDTH-1], r_data[WIDTH-1:1]};
                end
            endcase
        end
    end
`endif

    assign sru.out   = r_data;
    assign sru.carry = r_carry;
    assign sru.busy  = (r_state != ST_IDLE);
    assign sru.done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_rotate_unit.sv
// Directed bench for shift_rotate_unit, WIDTH=8.
// Expected values are hand-computed constants.
// The expected latency depends on whether the build defines SRU_BARREL_EN.
module tb_shift_rotate_unit;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    shift_rotate_unit_if #(.WIDTH(8)) sru ();

    shift_rotate_unit #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .sru (sru)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from the start edge to the edge after which done is seen high.
    function automatic int exp_lat(input logic [2:0] a);
`ifdef SRU_BARREL_EN
        return 0;
`else
        return int'(a);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation and check latency, busy span, result, carry, the
    // done pulse width and that the result holds afterwards.
    task automatic do_op(input string nm, input logic [1:0] m, input logic [7:0] d,
                         input logic [2:0] a, input logic [7:0] eo, input logic ec);
        int k;
        int busy_cnt;
        sru.start = 1'b1;
        sru.in    = d;
        sru.amt   = a;
        sru.mode  = m;
        tick();
        sru.start = 1'b0;
        sru.in    = ~d;       // the captured operand must not follow the port
        sru.amt   = 3'd5;
        sru.mode  = ~m;
        k = 0;
        busy_cnt = 0;
        while (sru.done !== 1'b1 && k < 40) begin
            if (sru.busy === 1'b1) busy_cnt++;
            tick();
            k++;
        end
        vectors++;
        if (sru.done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done_timeout: got done=%b after %0d cycles, required 1", nm, sru.done, k);
        end
        vectors++;
        if (k != exp_lat(a)) begin
            miscompares++;
            $display("FAIL %s latency: got %0d, required %0d", nm, k, exp_lat(a));
        end
        vectors++;
        if (busy_cnt != exp_lat(a) || sru.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_span: got %0d cycles before done (busy at done=%b), required %0d with busy=1",
                     nm, busy_cnt, sru.busy, exp_lat(a));
        end
        vectors++;
        if (sru.out !== eo) begin
            miscompares++;
            $display("FAIL %s out: got %b, required %b", nm, sru.out, eo);
        end
        vectors++;
        if (sru.carry !== ec) begin
            miscompares++;
            $display("FAIL %s carry: got %b, required %b", nm, sru.carry, ec);
        end
        tick();
        vectors++;
        if (sru.done !== 1'b0 || sru.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s done_pulse: got done=%b busy=%b, required 0/0", nm, sru.done, sru.busy);
        end
        repeat (2) tick();
        vectors++;
        if (sru.out !== eo || sru.carry !== ec) begin
            miscompares++;
            $display("FAIL %s hold: got out=%b carry=%b, required %b/%b", nm, sru.out, sru.carry, eo, ec);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        sru.start = 1'b0;
        sru.in    = 8'h00;
        sru.amt   = 3'd0;
        sru.mode  = 2'b00;
        repeat (3) tick();
        vectors++;
        if (sru.out !== 8'h00 || sru.carry !== 1'b0 || sru.busy !== 1'b0 || sru.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got out=%b carry=%b busy=%b done=%b, required 0/0/0/0",
                     sru.out, sru.carry, sru.busy, sru.done);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lsl();
        do_op("lsl1",   2'b00, 8'b11000011, 3'd1, 8'b10000110, 1'b1);
        do_op("lsl7",   2'b00, 8'b00000011, 3'd7, 8'b10000000, 1'b1);
    endtask

    task automatic test_rol();
        do_op("rol5",   2'b01, 8'b11000011, 3'd5, 8'b01111000, 1'b0);
        do_op("rol1",   2'b01, 8'b10000000, 3'd1, 8'b00000001, 1'b1);
        do_op("rol7",   2'b01, 8'b00000001, 3'd7, 8'b10000000, 1'b0);
    endtask

    task automatic test_right();
        do_op("asr3",   2'b11, 8'b10010000, 3'd3, 8'b11110010, 1'b0);
        do_op("lsr3",   2'b10, 8'b10010000, 3'd3, 8'b00010010, 1'b0);
        do_op("lsr7",   2'b10, 8'b11000001, 3'd7, 8'b00000001, 1'b1);
        do_op("asr7",   2'b11, 8'b11000001, 3'd7, 8'b11111111, 1'b1);
        do_op("asr2p",  2'b11, 8'b01000110, 3'd2, 8'b00010001, 1'b1);
    endtask

    task automatic test_amt_zero();
        // The preceding op leaves carry=1, so carry=0 here proves it is cleared on accept.
        do_op("lsl0",   2'b00, 8'b10100101, 3'd0, 8'b10100101, 1'b0);
        do_op("asr7c",  2'b11, 8'b11000001, 3'd7, 8'b11111111, 1'b1);
        do_op("rol0",   2'b01, 8'b10100101, 3'd0, 8'b10100101, 1'b0);
        do_op("lsr0",   2'b10, 8'b10100101, 3'd0, 8'b10100101, 1'b0);
        do_op("asr0",   2'b11, 8'b10100101, 3'd0, 8'b10100101, 1'b0);
    endtask

    // start held high for the whole busy window must yield exactly one operation.
    task automatic test_start_while_busy(input logic [2:0] a, input logic [7:0] eo);
        int dones;
        int k;
        sru.start = 1'b1;
        sru.in    = 8'b00001111;
        sru.amt   = a;
        sru.mode  = 2'b00;
        tick();
        sru.in  = 8'hFF;
        sru.amt = 3'd1;
        dones = 0;
        k = 0;
        while (sru.busy === 1'b1 && k < 40) begin
            if (sru.done === 1'b1) dones++;
            tick();
            k++;
        end
        sru.start = 1'b0;
        tick();
        vectors++;
        if (dones != 1 || sru.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_amt%0d: got %0d done pulses (busy=%b), required 1 (busy=0)", a, dones, sru.busy);
        end
        vectors++;
        if (sru.out !== eo || sru.carry !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_ignore_amt%0d result: got %b/%b, required %b/0", a, sru.out, sru.carry, eo);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        sru.start = 1'b1;
        sru.in    = 8'b11000001;
        sru.amt   = 3'd7;
        sru.mode  = 2'b10;
        tick();             // E0: enter SHIFT
        sru.start = 1'b0;
        tick();             // second SHIFT cycle
        tick();             // third SHIFT cycle
        rst = 1'b1;
        tick();
        vectors++;
        if (sru.out !== 8'h00 || sru.carry !== 1'b0 || sru.busy !== 1'b0 || sru.done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got out=%b carry=%b busy=%b done=%b, required 0/0/0/0",
                     sru.out, sru.carry, sru.busy, sru.done);
        end
        rst = 1'b0;
        do_op("post_rst", 2'b00, 8'b11000011, 3'd1, 8'b10000110, 1'b1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        sru.start   = 1'b0;
        sru.in      = '0;
        sru.amt     = '0;
        sru.mode    = '0;
        test_reset();
        test_lsl();
        test_rol();
        test_right();
        test_amt_zero();
        test_start_while_busy(3'd0, 8'b00001111);
        test_start_while_busy(3'd2, 8'b00111100);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
